// File: rtl/buf_rd_pkg.sv
// Shared defaults and FSM state type for the buffer read streamer.
package buf_rd_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ELEM_W     = 8;
  localparam int ELEMS_PER_WORD = DEF_DATA_W / DEF_ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } buf_rd_state_t;

endpackage

// File: rtl/buf_rd_word_fifo.sv
// Small synchronous word FIFO with first-word-fall-through read data and an occupancy count.
module buf_rd_word_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/buf_rd_streamer.sv
// Reads a block of RAM words and streams them as int8 elements over valid/ready.
// Optional stall counter port enabled by defining BUF_RD_STALL_CNT_EN.
module buf_rd_streamer
  import buf_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ELEM_W     = DEF_ELEM_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              ram_ce,
  output logic [11:0]       ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last
`ifdef BUF_RD_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int EPW   = DATA_W / ELEM_W;
  localparam int IDX_W = $clog2(EPW);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]  WCNT_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EPW - 1);

  buf_rd_state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   loaded;
  logic              inflight;
  logic [DATA_W-1:0] word_q;
  logic              held;
  logic              word_last;
  logic [IDX_W-1:0]  idx;

  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic              fire, need_load, load, last_fire;
  logic [DATA_W-1:0] load_word;
  logic [ADDR_W-1:0] addr_w;

  // Credit counts words already buffered plus the one read still in the RAM pipeline.
  assign ram_ce = (state == ST_READ) && (issued < num_q) &&
                  ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign addr_w   = base_q + issued[ADDR_W-1:0];
  assign ram_addr = ram_ce ? 12'(addr_w) : 12'd0;

  assign fifo_empty = (fifo_count == '0);
  assign fire       = held && out_ready;
  assign need_load  = !held || (fire && idx == IDX_LAST);
  // An arriving word bypasses an empty FIFO so startup and handoff cost no extra cycle.
  assign load       = need_load && (!fifo_empty || inflight);
  assign fifo_pop   = need_load && !fifo_empty;
  assign fifo_push  = inflight && !(need_load && fifo_empty);
  assign load_word  = fifo_empty ? ram_dout : fifo_rdata;

  assign out_valid = held;
  assign out_data  = held ? word_q[int'(idx)*ELEM_W +: ELEM_W] : '0;
  assign out_last  = held && word_last && (idx == IDX_LAST);
  assign last_fire = fire && out_last;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  buf_rd_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (ram_dout),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = (num_words == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (ram_ce && issued == num_q - WCNT_ONE) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_fire && fifo_empty && !inflight) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      loaded    <= '0;
      inflight  <= 1'b0;
      word_q    <= '0;
      held      <= 1'b0;
      word_last <= 1'b0;
      idx       <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= ram_ce;
      if (state == ST_IDLE && start) begin
        base_q <= base_addr;
        num_q  <= num_words;
        issued <= '0;
        loaded <= '0;
      end else if (ram_ce) begin
        issued <= issued + WCNT_ONE;
      end
      if (load) begin
        word_q    <= load_word;
        held      <= 1'b1;
        idx       <= '0;
        word_last <= (loaded == num_q - WCNT_ONE);
        loaded    <= loaded + WCNT_ONE;
      end else if (fire) begin
        idx <= idx + IDX_ONE;
        if (idx == IDX_LAST) held <= 1'b0;
      end
    end
  end

`ifdef BUF_RD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cycles <= '0;
    else if (state == ST_IDLE && start)     stall_cycles <= '0;
    else if (held && !out_ready && stall_cycles != 16'hFFFF)
                                            stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_buf_rd_streamer.sv
// Randomized self-checking bench: block-level element queue model against the streamer.
module tb_buf_rd_streamer;
  import buf_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic        busy, done, ram_ce, out_valid, out_ready, out_last;
  logic [11:0] ram_addr;
  logic [31:0] ram_dout;
  logic [7:0]  out_data;
`ifdef BUF_RD_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  logic [31:0] mem [1024];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Registered-read buffer model.
  always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_addr[9:0]];

  buf_rd_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .ram_ce    (ram_ce),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef BUF_RD_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_ce"},    ram_ce, 0);
    check({tag, "_addr"},  ram_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_last"},  out_last, 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 toggle plus 10-cycle low burst, 3 low for 5 cycles after valid
  task automatic run_block(input int base, input int num, input int mode,
                           input int inject_at, input int reset_at);
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    int         exp_a[$];
    logic [31:0] w;
    int cyc, last_fire, first_fire, fired, stall_exp, vcyc, budget;
    bit fin, seen_v;

    for (int i = 0; i < num; i++) begin
      exp_a.push_back((base + i) % 1024);
      w = mem[(base + i) % 1024];
      for (int b = 0; b < ELEMS_PER_WORD; b++) begin
        exp_d.push_back(w[8*b +: 8]);
        exp_l.push_back(i == num - 1 && b == ELEMS_PER_WORD - 1);
      end
    end

    @(negedge clk);
    base_addr = 10'(base);
    num_words = 11'(num);
    start     = 1'b1;
    out_ready = (mode == 0);
    cyc = 0; last_fire = 0; first_fire = -1; fired = 0; stall_exp = 0; vcyc = 0;
    fin = 1'b0; seen_v = 1'b0;
    budget = 8 * num + 50;

    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inject_at) begin
        start     = 1'b1;
        base_addr = 10'($urandom);
        num_words = 11'($urandom_range(1, 8));
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = (cyc >= 8 && cyc < 18) ? 1'b0 : (cyc % 2 == 0);
        default: begin
          if (!seen_v && out_valid) begin seen_v = 1'b1; vcyc = cyc; end
          out_ready = seen_v && (cyc - vcyc >= 5);
        end
      endcase

      if (cyc == 1) check("busy_on", busy, 1);
      if (num == 0) begin
        check("zero_ce", ram_ce, 0);
        check("zero_valid", out_valid, 0);
      end
      if (ram_ce) begin
        if (exp_a.size() == 0) check("extra_issue", 1, 0);
        else check("addr", ram_addr, exp_a.pop_front());
      end
      if (mode == 2) check("fifo_le_depth", dut.fifo_count <= 2, 1);
      if (out_valid && !out_ready) stall_exp++;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) check("extra_elem", 1, 0);
        else begin
          check("data", out_data, exp_d.pop_front());
          check("last", out_last, exp_l.pop_front());
          if (first_fire < 0) first_fire = cyc;
          if (mode == 0) check("gap", cyc, first_fire + fired);
          fired++;
          last_fire = cyc;
        end
      end

      if (done) begin
        check("done_at", cyc, last_fire + 1);
        check("elems_left", exp_d.size(), 0);
        check("words_left", exp_a.size(), 0);
`ifdef BUF_RD_STALL_CNT_EN
        check("stall", stall_cycles, (stall_exp > 65535) ? 65535 : stall_exp);
        if (mode == 3) check("stall5", stall_cycles, 5);
`endif
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
        fin = 1'b1;
      end else if (cyc > budget) begin
        check("timeout", 0, 1);
        fin = 1'b1;
      end
    end
    if (mode == 0 && num > 0) check("startup", first_fire, 3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    #12;
    check_all_zero("reset");
    check("reset_fifo", dut.fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_block(0, 2, 0, -1, -1);
    run_block(1022, 4, 0, -1, -1);
    run_block($urandom_range(0, 1023), 3, 2, -1, -1);
    run_block(5, 0, 0, -1, -1);
    run_block(100, 5, 1, 6, -1);
    run_block(200, 6, 0, -1, 9);
    run_block(300, 3, 0, -1, -1);
    for (int k = 0; k < 6; k++)
      run_block($urandom_range(0, 1023), $urandom_range(1, 12), 1, -1, -1);
    run_block(517, 1024, 0, -1, -1);
    run_block(40, 1, 3, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
